// File: rtl/isa_pkg.sv
// Shared definitions for the 16-bit ISA core: opcodes, ALU operations,
// controller state encodings, instruction field positions and the
// control-word bundle driven by the main controller.
package isa_pkg;

    // Instruction field positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;

    // Opcodes (instr[15:12])
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // PC source select
    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // Controller states
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Control word produced by the decoder for one cycle
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       halted;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it
// takes status (opcode, mem_ready, alu_zero) and drives every control line.
interface multicycle_control_if #(
    parameter int RETIRE_W = 16
);
    logic [3:0]          opcode_in;
    logic                mem_ready;
    logic                alu_zero;
    logic                mem_read;
    logic                mem_write;
    logic                i_or_d;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                RegDst;
    logic                RegWrite;
    logic                mem_to_reg;
    logic                alu_src_b;
    logic [2:0]          alu_op;
    logic [2:0]          state_out;
    logic                halted;
    logic                illegal;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  opcode_in, mem_ready, alu_zero,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
               RegDst, RegWrite, mem_to_reg, alu_src_b, alu_op,
               state_out, halted, illegal, retired
    );

    modport slave (
        output opcode_in, mem_ready, alu_zero,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
               RegDst, RegWrite, mem_to_reg, alu_src_b, alu_op,
               state_out, halted, illegal, retired
    );
endinterface

// File: rtl/control_decode.sv
// Combinational control decode: maps the registered state, latched opcode
// and the two status inputs to the cycle's control word, next state and
// the retire/opcode-latch strobes.
module control_decode
    import isa_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output ctrl_t      ctrl,
    output state_t     next_state,
    output logic       retire,
    output logic       load_opcode
);

    // Per-state control and next-state decode
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        ctrl        = '0;
        next_state  = state;
        retire      = 1'b0;
        load_opcode = 1'b0;

        unique case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_INC;
                    load_opcode   = 1'b1;
                    next_state    = S_DECODE;
                end
            end

            S_DECODE: begin
                if (opcode <= OP_BEQ) begin
                    next_state = S_EXEC;
                end else if (opcode == OP_J) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_JUMP;
                    retire        = 1'b1;
                    next_state    = S_FETCH;
                end else if (opcode == OP_HALT) begin
                    next_state = S_HALT;
                end else begin
                    ctrl.illegal = 1'b1;
                    next_state   = S_FETCH;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                        ctrl.alu_op = opcode[2:0];
                        next_state  = S_WB;
                    end
                    OP_ADDI: begin
                        ctrl.alu_src_b = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                        next_state     = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ctrl.alu_src_b = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                        next_state     = S_MEM;
                    end
                    OP_BEQ: begin
                        ctrl.alu_op   = ALU_SUB;
                        ctrl.pc_write = alu_zero;
                        ctrl.pc_src   = PC_BRANCH;
                        retire        = 1'b1;
                        next_state    = S_FETCH;
                    end
                    default: next_state = S_FETCH;
                endcase
            end

            S_MEM: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = (opcode == OP_LW);
                ctrl.mem_write = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end

            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = (opcode <= OP_SLT);
                ctrl.mem_to_reg = (opcode == OP_LW);
                retire          = 1'b1;
                next_state      = S_FETCH;
            end

            S_HALT: begin
                ctrl.halted = 1'b1;
            end

            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller. Holds the state register, the opcode latched
// during FETCH and the retired-instruction counter; control lines come from
// a decode of registered state so the level-sensitive RegWrite stays clean.
module multicycle_control
    import isa_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_t              state;
    state_t              next_state;
    logic [3:0]          opcode_q;
    logic [RETIRE_W-1:0] retire_cnt;
    ctrl_t               ctrl;
    ctrl_t               ctrl_out;
    logic                retire;
    logic                load_opcode;

    control_decode u_decode (
        .state       (state),
        .opcode      (opcode_q),
        .mem_ready   (bus.mem_ready),
        .alu_zero    (bus.alu_zero),
        .ctrl        (ctrl),
        .next_state  (next_state),
        .retire      (retire),
        .load_opcode (load_opcode)
    );

    // State, opcode and retire-counter registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= S_FETCH;
            opcode_q   <= '0;
            retire_cnt <= '0;
        end else begin
            state <= next_state;
            if (load_opcode) opcode_q <= bus.opcode_in;
            if (retire) retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

    // Force every output low while reset is held, even before the state clears
    assign ctrl_out       = rst ? '0 : ctrl;
    assign bus.mem_read   = ctrl_out.mem_read;
    assign bus.mem_write  = ctrl_out.mem_write;
    assign bus.i_or_d     = ctrl_out.i_or_d;
    assign bus.ir_write   = ctrl_out.ir_write;
    assign bus.pc_write   = ctrl_out.pc_write;
    assign bus.pc_src     = ctrl_out.pc_src;
    assign bus.RegDst     = ctrl_out.reg_dst;
    assign bus.RegWrite   = ctrl_out.reg_write;
    assign bus.mem_to_reg = ctrl_out.mem_to_reg;
    assign bus.alu_src_b  = ctrl_out.alu_src_b;
    assign bus.alu_op     = ctrl_out.alu_op;
    assign bus.halted     = ctrl_out.halted;
    assign bus.illegal    = ctrl_out.illegal;
    assign bus.state_out  = rst ? 3'd0 : state;
    assign bus.retired    = rst ? '0 : retire_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// into a per-cycle list of stimulus and expected outputs pushed to queues;
// the cycle runner pops both, drives the inputs and compares every output.
module tb_multicycle_control;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef struct packed {
        logic [2:0]  st;
        logic        mr, mw, iod, irw, pcw;
        logic [1:0]  pcs;
        logic        rd, rw, m2r, asb;
        logic [2:0]  aop;
        logic        hlt, ill;
        logic [15:0] ret;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       az;
        logic [3:0] op;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    logic rst4;

    always #5 clk = ~clk;

    multicycle_control_if #(.RETIRE_W(16)) bus ();
    multicycle_control_if #(.RETIRE_W(4))  bus4 ();

    multicycle_control #(.RETIRE_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter instance used to reach the wrap point in few cycles
    multicycle_control #(.RETIRE_W(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    stim_t       stim_q[$];
    obs_t        exp_q[$];
    logic [15:0] exp_ret;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st  = bus.state_out;
        o.mr  = bus.mem_read;
        o.mw  = bus.mem_write;
        o.iod = bus.i_or_d;
        o.irw = bus.ir_write;
        o.pcw = bus.pc_write;
        o.pcs = bus.pc_src;
        o.rd  = bus.RegDst;
        o.rw  = bus.RegWrite;
        o.m2r = bus.mem_to_reg;
        o.asb = bus.alu_src_b;
        o.aop = bus.alu_op;
        o.hlt = bus.halted;
        o.ill = bus.illegal;
        o.ret = bus.retired;
        return o;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o     = '0;
        o.st  = st;
        o.ret = exp_ret;
        return o;
    endfunction

    task automatic push(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Expand one instruction into expected per-cycle outputs.
    // fw: FETCH wait cycles, mw: MEM wait cycles, abort: stop before MEM completes.
    task automatic push_instr(input logic [3:0] op, input int fw, input int mw,
                              input logic az, input bit abort);
        obs_t  e;
        stim_t s;
        s.rst = 1'b0;
        s.az  = az;
        s.op  = op;

        s.mr = 1'b0;
        for (int i = 0; i < fw; i++) begin
            e = base(ST_FETCH);
            e.mr = 1'b1;
            push(s, e);
        end
        s.mr = 1'b1;
        e = base(ST_FETCH);
        e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        push(s, e);

        e = base(ST_DECODE);
        if (op == 4'h9) begin
            e.pcw = 1'b1; e.pcs = 2'd2;
            push(s, e);
            exp_ret++;
            return;
        end else if (op == 4'hF) begin
            push(s, e);
            return;
        end else if (op > 4'h8) begin
            e.ill = 1'b1;
            push(s, e);
            return;
        end
        push(s, e);

        e = base(ST_EXEC);
        if (op <= 4'h4) begin
            e.aop = op[2:0];
        end else if (op == 4'h8) begin
            e.aop = 3'd1; e.pcs = 2'd1; e.pcw = az;
        end else begin
            e.asb = 1'b1;
        end
        push(s, e);
        if (op == 4'h8) begin
            exp_ret++;
            return;
        end

        if (op == 4'h6 || op == 4'h7) begin
            e = base(ST_MEM);
            e.iod = 1'b1;
            e.mr  = (op == 4'h6);
            e.mw  = (op == 4'h7);
            s.mr  = 1'b0;
            for (int i = 0; i < mw; i++) push(s, e);
            if (abort) return;
            s.mr = 1'b1;
            push(s, e);
            if (op == 4'h7) begin
                exp_ret++;
                return;
            end
        end

        e = base(ST_WB);
        e.rw  = 1'b1;
        e.rd  = (op <= 4'h4);
        e.m2r = (op == 4'h6);
        push(s, e);
        exp_ret++;
    endtask

    // One reset cycle: every output, state and counter read as zero
    task automatic push_reset();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        s.mr  = 1'b1;
        push(s, '0);
        exp_ret = '0;
    endtask

    // Drive each queued cycle and compare once outputs settle
    task automatic run_queue(input string tag);
        stim_t s;
        obs_t  e;
        int    idx = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            rst           = s.rst;
            bus.mem_ready = s.mr;
            bus.alu_zero  = s.az;
            bus.opcode_in = s.op;
            #1;
            if (exp_q.size() == 0) begin
                check({tag, " empty_sb"}, 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s[%0d]", tag, idx), 64'(sample()), 64'(e));
            end
            idx++;
        end
    endtask

    initial begin
        stim_t s;
        obs_t  e;

        rst            = 1'b1;
        rst4           = 1'b1;
        bus.opcode_in  = 4'h0;
        bus.mem_ready  = 1'b0;
        bus.alu_zero   = 1'b0;
        bus4.opcode_in = 4'h9;
        bus4.mem_ready = 1'b1;
        bus4.alu_zero  = 1'b0;
        exp_ret        = '0;

        push_reset();
        push_reset();
        run_queue("reset");

        push_instr(4'h0, 0, 0, 1'b0, 1'b0); run_queue("add");
        push_instr(4'h1, 1, 0, 1'b1, 1'b0); run_queue("sub_fwait");
        push_instr(4'h2, 0, 0, 1'b0, 1'b0); run_queue("and");
        push_instr(4'h3, 0, 0, 1'b0, 1'b0); run_queue("or");
        push_instr(4'h4, 0, 0, 1'b0, 1'b0); run_queue("slt");
        push_instr(4'h5, 0, 0, 1'b0, 1'b0); run_queue("addi");
        push_instr(4'h6, 0, 2, 1'b0, 1'b0); run_queue("lw_wait2");
        push_instr(4'h6, 0, 0, 1'b0, 1'b0); run_queue("lw");
        push_instr(4'h7, 0, 1, 1'b0, 1'b0); run_queue("sw_wait1");
        push_instr(4'h7, 0, 0, 1'b0, 1'b0); run_queue("sw");
        push_instr(4'h8, 0, 0, 1'b1, 1'b0); run_queue("beq_taken");
        push_instr(4'h8, 0, 0, 1'b0, 1'b0); run_queue("beq_not");
        push_instr(4'h9, 0, 0, 1'b0, 1'b0); run_queue("jump");
        push_instr(4'hC, 0, 0, 1'b0, 1'b0); run_queue("illegal_c");
        push_instr(4'hA, 0, 0, 1'b0, 1'b0); run_queue("illegal_a");

        // HALT parks for 20 cycles whatever the inputs, then reset recovers it
        push_instr(4'hF, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            s     = '0;
            s.mr  = i[0];
            s.az  = i[1];
            s.op  = 4'h0;
            e     = base(ST_HALT);
            e.hlt = 1'b1;
            push(s, e);
        end
        push_reset();
        push_instr(4'h0, 0, 0, 1'b0, 1'b0);
        run_queue("halt");

        // Reset while SW waits in MEM: mem_write drops in the reset cycle
        push_instr(4'h9, 0, 0, 1'b0, 1'b0);
        push_instr(4'h7, 0, 2, 1'b0, 1'b1);
        push_reset();
        push_instr(4'h9, 0, 0, 1'b0, 1'b0);
        run_queue("sw_abort");

        // Counter wrap on the narrow instance: 15 jumps then one more
        @(negedge clk);
        rst4 = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        check("wrap_before", 64'(bus4.retired), 64'd15);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("wrap_after", 64'(bus4.retired), 64'd0);
        check("wrap_state", 64'(bus4.state_out), 64'(ST_FETCH));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
